id_check: RTL and testbench

- Front stage of the login path: collects a 4-digit hex player ID from the user keypad and searches the ID ROM for it.
- On a hit, it presents matchedID, the 3-bit internal player index and the guest flag to the password stage.
- It holds these outputs until the password stage pulses logout, then rearms for the next user.

---
 rtl/id_check_if.sv | 24 ++
 rtl/id_check.sv | 163 ++++++++++++++++
 tb/tb_id_check.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_check_if.sv
// Keypad, ID ROM and password-stage signals of the login front stage.
// The master side is the environment (keypad, ROM, password stage); the slave side is id_check.
interface id_check_if;
   logic        UserLoad;
   logic [3:0]  UserDigit;
   logic [4:0]  addr;
   logic [15:0] data_rom_ID;
   logic        logout;
   logic        matchedID;
   logic [2:0]  ID_internal_from_ID;
   logic        isGuest_from_ID;
   logic        idFail;
   logic        IDFailLED;

   modport master (
      output UserLoad, UserDigit, data_rom_ID, logout,
      input  addr, matchedID, ID_internal_from_ID, isGuest_from_ID, idFail, IDFailLED
   );

   modport slave (
      input  UserLoad, UserDigit, data_rom_ID, logout,
      output addr, matchedID, ID_internal_from_ID, isGuest_from_ID, idFail, IDFailLED
   );
endinterface

// File: rtl/id_check.sv
// Login front stage: collects a 4-digit hex ID, searches the ID ROM in ascending
// index order and holds the matched player index until the password stage logs out.
//
// state    | meaning
// DIGIT_1  | waiting for first digit (ID[15:12]); capture clears the fail LED
// DIGIT_2  | waiting for ID[11:8]
// DIGIT_3  | waiting for ID[7:4]
// DIGIT_4  | waiting for ID[3:0]; capture starts the search at index 0
// SET_ADDR | drive ROM address for current index
// ROM_WAIT | wait ROM_LAT cycles for ROM data
// COMPARE  | compare ROM data with entered ID
// MATCHED  | hold match outputs until logout
// FAIL     | one-cycle idFail pulse, set fail LED
module id_check #(
   parameter int          NUM_IDS    = 8,
   parameter int          ROM_LAT    = 2,
   parameter int          GUEST_IDX  = 7,
   parameter logic [15:0] INVALID_ID = 16'hFFFF
) (
   input  logic    clk,
   input  logic    rst,
   id_check_if.slave bus
);

   localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ROM_LAT - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(NUM_IDS - 1);
   localparam logic [2:0]       GUEST     = 3'(GUEST_IDX);

   typedef enum logic [3:0] {
      DIGIT_1, DIGIT_2, DIGIT_3, DIGIT_4,
      SET_ADDR, ROM_WAIT, COMPARE, MATCHED, FAIL
   } state_t;

   state_t           state, state_n;
   logic [15:0]      entered_id, entered_id_n;
   logic [2:0]       idx, idx_n;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
   logic [4:0]       addr_q, addr_n;
   logic             matched_q, matched_n;
   logic [2:0]       id_int_q, id_int_n;
   logic             guest_q, guest_n;
   logic             fail_led_q, fail_led_n;
   logic             id_fail;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DIGIT_1;
         entered_id <= '0;
         idx        <= '0;
         wait_cnt   <= '0;
         addr_q     <= '0;
         matched_q  <= 1'b0;
         id_int_q   <= '0;
         guest_q    <= 1'b0;
         fail_led_q <= 1'b0;
      end else begin
         state      <= state_n;
         entered_id <= entered_id_n;
         idx        <= idx_n;
         wait_cnt   <= wait_cnt_n;
         addr_q     <= addr_n;
         matched_q  <= matched_n;
         id_int_q   <= id_int_n;
         guest_q    <= guest_n;
         fail_led_q <= fail_led_n;
      end
   end

   always_comb begin
      state_n      = state;
      entered_id_n = entered_id;
      idx_n        = idx;
      wait_cnt_n   = wait_cnt;
      addr_n       = addr_q;
      matched_n    = matched_q;
      id_int_n     = id_int_q;
      guest_n      = guest_q;
      fail_led_n   = fail_led_q;
      id_fail      = 1'b0;

      case (state)
         DIGIT_1: if (bus.UserLoad) begin
            entered_id_n[15:12] = bus.UserDigit;
            fail_led_n          = 1'b0;
            state_n             = DIGIT_2;
         end
         DIGIT_2: if (bus.UserLoad) begin
            entered_id_n[11:8] = bus.UserDigit;
            state_n            = DIGIT_3;
         end
         DIGIT_3: if (bus.UserLoad) begin
            entered_id_n[7:4] = bus.UserDigit;
            state_n           = DIGIT_4;
         end
         DIGIT_4: if (bus.UserLoad) begin
            entered_id_n[3:0] = bus.UserDigit;
            idx_n             = '0;
            state_n           = SET_ADDR;
         end
         SET_ADDR: begin
            addr_n     = {2'b00, idx};
            wait_cnt_n = '0;
            state_n    = ROM_WAIT;
         end
         ROM_WAIT: begin
            wait_cnt_n = wait_cnt + CNT_W'(1);
            if (wait_cnt == LAST_WAIT) state_n = COMPARE;
         end
         COMPARE: begin
            // The filler value can never match, so an all-F entry always fails.
            if ((bus.data_rom_ID == entered_id) && (bus.data_rom_ID != INVALID_ID)) begin
               state_n = MATCHED;
            end else if (idx == LAST_IDX) begin
               state_n = FAIL;
            end else begin
               idx_n   = idx + 3'd1;
               state_n = SET_ADDR;
            end
         end
         MATCHED: begin
            if (bus.logout) begin
               matched_n    = 1'b0;
               id_int_n     = '0;
               guest_n      = 1'b0;
               entered_id_n = '0;
               idx_n        = '0;
               addr_n       = '0;
               state_n      = DIGIT_1;
            end else begin
               matched_n = 1'b1;
               id_int_n  = idx;
               guest_n   = (idx == GUEST);
            end
         end
         FAIL: begin
            id_fail      = 1'b1;
            fail_led_n   = 1'b1;
            entered_id_n = '0;
            state_n      = DIGIT_1;
         end
         default: begin
            entered_id_n = '0;
            idx_n        = '0;
            wait_cnt_n   = '0;
            addr_n       = '0;
            matched_n    = 1'b0;
            id_int_n     = '0;
            guest_n      = 1'b0;
            fail_led_n   = 1'b0;
            state_n      = DIGIT_1;
         end
      endcase
   end

   assign bus.addr                = addr_q;
   assign bus.matchedID           = matched_q;
   assign bus.ID_internal_from_ID = id_int_q;
   assign bus.isGuest_from_ID     = guest_q;
   assign bus.idFail              = id_fail;
   assign bus.IDFailLED           = fail_led_q;

endmodule

// File: tb/tb_id_check.sv
// Bench for id_check: ROM model with two-cycle read latency, expected search
// results queued at entry time and popped when the DUT reports a hit or a miss.
module tb_id_check;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_check_if bus();

   id_check dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] rom [8];
   logic [15:0] rom_d1;

   always @(posedge clk) begin
      rom_d1          <= rom[bus.addr[2:0]];
      bus.data_rom_ID <= rom_d1;
   end

   typedef struct {
      bit hit;
      int idx;
      bit guest;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   function automatic exp_t model(input logic [15:0] id);
      exp_t e;
      e.hit = 1'b0; e.idx = 0; e.guest = 1'b0; e.lat = 32;
      if (id != 16'hFFFF) begin
         for (int i = 0; i < 8; i++) begin
            if (!e.hit && rom[i] == id) begin
               e.hit   = 1'b1;
               e.idx   = i;
               e.guest = (i == 7);
               e.lat   = 4 * (i + 1) + 1;
            end
         end
      end
      return e;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_digit(input logic [3:0] d);
      bus.UserLoad  = 1'b1;
      bus.UserDigit = d;
      cycle();
      bus.UserLoad  = 1'b0;
   endtask

   task automatic enter_id(input logic [15:0] id, input bit push);
      logic [15:0] v;
      v = id;
      if (push) sb.push_back(model(v));
      pulse_digit(v[15:12]);
      pulse_digit(v[11:8]);
      pulse_digit(v[7:4]);
      pulse_digit(v[3:0]);
   endtask

   task automatic do_logout();
      bus.logout = 1'b1;
      cycle();
      bus.logout = 1'b0;
   endtask

   task automatic wait_result();
      exp_t e;
      int   n;
      e = sb.pop_front();
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         cycle();
         n = i;
         if (n == 1) begin
            vec_cnt++;
            if (bus.addr !== 5'd0)
               $display("FAIL addr_first actual=%0d required=0", bus.addr);
            if (bus.addr !== 5'd0) err_cnt++;
         end
         if (n == 5 && (!e.hit || e.idx >= 1)) begin
            vec_cnt++;
            if (bus.addr !== 5'd1) begin
               $display("FAIL addr_second actual=%0d required=1", bus.addr);
               err_cnt++;
            end
         end
         if (bus.matchedID === 1'b1 || bus.idFail === 1'b1) break;
      end
      vec_cnt++;
      if (e.hit) begin
         if (bus.matchedID !== 1'b1 || n != e.lat || bus.ID_internal_from_ID !== 3'(e.idx)
             || bus.isGuest_from_ID !== e.guest) begin
            $display("FAIL match actual=(m%0d lat%0d idx%0d g%0d) required=(m1 lat%0d idx%0d g%0d)",
                     bus.matchedID, n, bus.ID_internal_from_ID, bus.isGuest_from_ID,
                     e.lat, e.idx, e.guest);
            err_cnt++;
         end
      end else begin
         if (bus.idFail !== 1'b1 || n != e.lat || bus.matchedID !== 1'b0) begin
            $display("FAIL miss actual=(f%0d lat%0d m%0d) required=(f1 lat%0d m0)",
                     bus.idFail, n, bus.matchedID, e.lat);
            err_cnt++;
         end
         cycle();
         vec_cnt++;
         if (bus.idFail !== 1'b0 || bus.IDFailLED !== 1'b1 || bus.matchedID !== 1'b0) begin
            $display("FAIL fail_pulse actual=(f%0d led%0d m%0d) required=(f0 led1 m0)",
                     bus.idFail, bus.IDFailLED, bus.matchedID);
            err_cnt++;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      vec_cnt++;
      if (bus.matchedID !== 1'b0 || bus.ID_internal_from_ID !== 3'd0 || bus.isGuest_from_ID !== 1'b0
          || bus.addr !== 5'd0 || bus.idFail !== 1'b0) begin
         $display("FAIL %s actual=(m%0d idx%0d g%0d a%0d f%0d) required=(0 0 0 0 0)", tag,
                  bus.matchedID, bus.ID_internal_from_ID, bus.isGuest_from_ID, bus.addr, bus.idFail);
         err_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      check_idle("reset");
      vec_cnt++;
      if (bus.IDFailLED !== 1'b0) begin
         $display("FAIL reset_led actual=%0d required=0", bus.IDFailLED);
         err_cnt++;
      end
   endtask

   task automatic test_match_basic();
      enter_id(16'h0042, 1'b1);
      wait_result();
      do_logout();
   endtask

   task automatic test_guest_hold();
      enter_id(16'h0000, 1'b1);
      wait_result();
      for (int i = 0; i < 50; i++) begin
         if (i == 10 || i == 20 || i == 30) begin
            bus.UserLoad  = 1'b1;
            bus.UserDigit = 4'h9;
         end
         cycle();
         bus.UserLoad = 1'b0;
         vec_cnt++;
         if (bus.matchedID !== 1'b1 || bus.ID_internal_from_ID !== 3'd7 || bus.isGuest_from_ID !== 1'b1) begin
            $display("FAIL guest_hold cycle=%0d actual=(m%0d idx%0d g%0d) required=(1 7 1)", i,
                     bus.matchedID, bus.ID_internal_from_ID, bus.isGuest_from_ID);
            err_cnt++;
         end
      end
      do_logout();
   endtask

   task automatic test_fail();
      enter_id(16'hABCD, 1'b1);
      wait_result();
      sb.push_back(model(16'h1234));
      pulse_digit(4'h1);
      vec_cnt++;
      if (bus.IDFailLED !== 1'b0) begin
         $display("FAIL led_clear actual=%0d required=0", bus.IDFailLED);
         err_cnt++;
      end
      pulse_digit(4'h2);
      pulse_digit(4'h3);
      pulse_digit(4'h4);
      wait_result();
      do_logout();
   endtask

   task automatic test_invalid_id();
      enter_id(16'hFFFF, 1'b1);
      wait_result();
   endtask

   task automatic test_logout();
      enter_id(16'h1234, 1'b1);
      wait_result();
      bus.logout    = 1'b1;
      bus.UserLoad  = 1'b1;
      bus.UserDigit = 4'h5;
      cycle();
      bus.logout   = 1'b0;
      bus.UserLoad = 1'b0;
      check_idle("logout");
      enter_id(16'hBEEF, 1'b1);
      wait_result();
      do_logout();
   endtask

   task automatic test_reset_mid_search();
      enter_id(16'hBEEF, 1'b0);
      repeat (9) cycle();
      vec_cnt++;
      if (bus.addr !== 5'd2) begin
         $display("FAIL mid_addr actual=%0d required=2", bus.addr);
         err_cnt++;
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_idle("mid_reset");
      enter_id(16'hBEEF, 1'b1);
      wait_result();
      do_logout();
   endtask

   initial begin
      rom[0] = 16'h1234; rom[1] = 16'h0042; rom[2] = 16'hBEEF; rom[3] = 16'hFFFF;
      rom[4] = 16'hFFFF; rom[5] = 16'hFFFF; rom[6] = 16'hFFFF; rom[7] = 16'h0000;
      bus.UserLoad  = 1'b0;
      bus.UserDigit = 4'h0;
      bus.logout    = 1'b0;
      rst           = 1'b1;
      test_reset();
      test_match_basic();
      test_guest_hold();
      test_fail();
      test_invalid_id();
      test_logout();
      test_reset_mid_search();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
